mdio_master_mc: RTL and testbench



---
 rtl/mdio_master_mc.sv | 127 ++++++++++++
 tb/tb_mdio_master_mc.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master_mc.sv
// MDIO management master: Clause 22/45 frames, programmable MDC divider and preamble,
// split tristate pad interface and PHY-absent detection on reads.
module mdio_master_mc #(
    parameter int CLK_DIV      = 16,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        clause45,
    input  logic [1:0]  op,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        rd_err,
    output logic        ready,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_TA   = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] PRE_LAST = 6'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);

    logic [2:0]  state;
    logic [7:0]  div;
    logic [5:0]  cnt;
    logic [31:0] shreg;
    logic        rd_op;
    logic        rx_bit;
    logic        wrap;
    logic [31:0] frame;
    logic        is_read;

    assign ready   = (state == S_IDLE);
    assign wrap    = (div == DIV_LAST);
    assign frame   = {(clause45 ? 2'b00 : 2'b01), op, phy_addr, reg_addr, 2'b10, data_in};
    assign is_read = clause45 ? op[1] : (op == 2'b10);

    // shreg is shared: TX bits leave at the MSB while RX bits enter at the LSB,
    // so after the last shift the low half holds the read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            div        <= '0;
            cnt        <= '0;
            shreg      <= '0;
            rd_op      <= 1'b0;
            rx_bit     <= 1'b0;
            mdc        <= 1'b0;
            mdio_o     <= 1'b1;
            mdio_oe    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (state == S_IDLE) begin
                div <= '0;
                mdc <= 1'b0;
                if (start) begin
                    shreg   <= frame;
                    rd_op   <= is_read;
                    mdio_oe <= 1'b1;
                    if (PREAMBLE_LEN > 0) begin
                        state  <= S_PRE;
                        cnt    <= PRE_LAST;
                        mdio_o <= 1'b1;
                    end else begin
                        state  <= S_HDR;
                        cnt    <= 6'd13;
                        mdio_o <= frame[31];
                    end
                end
            end else begin
                div <= wrap ? 8'd0 : div + 8'd1;
                if (wrap) mdc <= ~mdc;
                if (wrap && !mdc) rx_bit <= mdio_i;
                if (wrap && mdc) begin
                    if (state == S_PRE) begin
                        if (cnt == 6'd0) begin
                            state  <= S_HDR;
                            cnt    <= 6'd13;
                            mdio_o <= shreg[31];
                        end else begin
                            cnt <= cnt - 6'd1;
                        end
                    end else begin
                        shreg  <= {shreg[30:0], rx_bit};
                        mdio_o <= shreg[30];
                        if (cnt != 6'd0) begin
                            cnt <= cnt - 6'd1;
                        end else if (state == S_HDR) begin
                            state   <= S_TA;
                            cnt     <= 6'd1;
                            mdio_oe <= ~rd_op;
                        end else if (state == S_TA) begin
                            state <= S_DATA;
                            cnt   <= 6'd15;
                        end else begin
                            // final bit: shreg[15] is the second TA bit as seen on the wire
                            state   <= S_IDLE;
                            mdc     <= 1'b0;
                            mdio_o  <= 1'b1;
                            mdio_oe <= 1'b0;
                            if (rd_op) begin
                                data_out   <= {shreg[14:0], rx_bit};
                                data_valid <= 1'b1;
                                rd_err     <= shreg[15];
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_master_mc.sv
// Directed bench for mdio_master_mc: a 4/32 instance for framing/read paths and a
// 2/0 instance for preamble suppression and back-to-back acceptance.
module tb_mdio_master_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic        clause45;
    logic [1:0]  op;
    logic [4:0]  phy_addr, reg_addr;
    logic [15:0] data_in;
    logic        mdio_i;

    logic [15:0] a_dout, b_dout;
    logic        a_dv, b_dv, a_err, b_err, a_rdy, b_rdy, a_mdc, b_mdc;
    logic        a_o, b_o, a_oe, b_oe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdio_master_mc #(.CLK_DIV(4), .PREAMBLE_LEN(32)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .clause45(clause45), .op(op),
        .phy_addr(phy_addr), .reg_addr(reg_addr), .data_in(data_in),
        .data_out(a_dout), .data_valid(a_dv), .rd_err(a_err), .ready(a_rdy),
        .mdc(a_mdc), .mdio_o(a_o), .mdio_oe(a_oe), .mdio_i(mdio_i));

    mdio_master_mc #(.CLK_DIV(2), .PREAMBLE_LEN(0)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .clause45(clause45), .op(op),
        .phy_addr(phy_addr), .reg_addr(reg_addr), .data_in(data_in),
        .data_out(b_dout), .data_valid(b_dv), .rd_err(b_err), .ready(b_rdy),
        .mdc(b_mdc), .mdio_o(b_o), .mdio_oe(b_oe), .mdio_i(mdio_i));

    // PHY drive for frame bit f (counted after the preamble); 1 models the pull-up.
    function automatic logic phy_bit(int f, logic [15:0] pd, logic ta2, logic hi);
        if (hi) return 1'b1;
        if (f == 15) return ta2;
        if (f >= 16 && f <= 31) return pd[31 - f];
        return 1'b1;
    endfunction

    // Launches one frame on instance sel (0=A, 1=B) and follows it until ready returns.
    task automatic run_frame(input bit sel, input int pre, input logic c45, input logic [1:0] o,
                             input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] d,
                             input logic [15:0] pdat, input logic pta2, input logic phy_hi,
                             input bit poke, output logic [31:0] bits, output logic [31:0] oeb,
                             output int cyc, output int rises, output int pre_bad,
                             output int dv_cnt, output logic dv_end, output bit acc);
        logic prev, cm, co, coe, cr, cdv;
        int n, f;
        bits = '0; oeb = '0; rises = 0; pre_bad = 0; dv_cnt = 0; dv_end = 1'b0;
        clause45 = c45; op = o; phy_addr = pa; reg_addr = ra; data_in = d; mdio_i = 1'b1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        acc = sel ? !b_rdy : !a_rdy;
        prev = 1'b0;
        n = 0;
        cr = 1'b0;
        while (!cr && n < 4000) begin
            @(posedge clk); #1;
            n++;
            cm  = sel ? b_mdc : a_mdc;
            co  = sel ? b_o   : a_o;
            coe = sel ? b_oe  : a_oe;
            cr  = sel ? b_rdy : a_rdy;
            cdv = sel ? b_dv  : a_dv;
            if (cdv) dv_cnt++;
            dv_end = cdv;
            if (!prev && cm) begin
                f = rises - pre;
                if (f >= 0 && f < 32) begin
                    bits[31 - f] = co;
                    oeb[31 - f]  = coe;
                end else if (f < 0 && !(co && coe)) begin
                    pre_bad++;
                end
                rises++;
            end
            if (prev && !cm) mdio_i = phy_bit(rises - pre, pdat, pta2, phy_hi);
            if (poke) begin
                if (n == 10) begin
                    op = ~o; data_in = 16'hFFFF; phy_addr = 5'h1F;
                end
                if (sel) start_b = (n == 10); else start_a = (n == 10);
            end
            prev = cm;
        end
        start_a = 1'b0; start_b = 1'b0;
        mdio_i = 1'b1;
        cyc = n;
    endtask

    logic [31:0] bits, oeb;
    int cyc, rises, pre_bad, dv_cnt;
    logic dv_end;
    bit acc;

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_rdy, a_mdc, a_o, a_oe, a_dv, a_err} !== 6'b101000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/mdc/o/oe/dv/err=%b expected 101000",
                     {a_rdy, a_mdc, a_o, a_oe, a_dv, a_err});
        end
        checks++;
        if (a_dout !== 16'h0000) begin
            errors++;
            $display("FAIL reset_dout: got %h expected 0000", a_dout);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_c22_write;
        run_frame(1'b0, 32, 1'b0, 2'b01, 5'h05, 5'h1F, 16'hA5C3, 16'h0, 1'b0, 1'b0, 1'b0,
                  bits, oeb, cyc, rises, pre_bad, dv_cnt, dv_end, acc);
        checks++;
        if (bits !== {2'b01, 2'b01, 5'h05, 5'h1F, 2'b10, 16'hA5C3}) begin
            errors++;
            $display("FAIL wr_bits: got %h expected %h", bits,
                     {2'b01, 2'b01, 5'h05, 5'h1F, 2'b10, 16'hA5C3});
        end
        checks++;
        if (oeb !== 32'hFFFF_FFFF || pre_bad != 0) begin
            errors++;
            $display("FAIL wr_oe: got oe %h pre_bad %0d expected ffffffff 0", oeb, pre_bad);
        end
        checks++;
        if (cyc != 512 || rises != 64) begin
            errors++;
            $display("FAIL wr_timing: got cyc %0d rises %0d expected 512 64", cyc, rises);
        end
        checks++;
        if (dv_cnt != 0) begin
            errors++;
            $display("FAIL wr_dv: got %0d pulses expected 0", dv_cnt);
        end
    endtask

    task automatic test_c22_read;
        run_frame(1'b0, 32, 1'b0, 2'b10, 5'h01, 5'h02, 16'h0, 16'h1234, 1'b0, 1'b0, 1'b0,
                  bits, oeb, cyc, rises, pre_bad, dv_cnt, dv_end, acc);
        checks++;
        if (bits[31:18] !== {2'b01, 2'b10, 5'h01, 5'h02} || oeb !== 32'hFFFC_0000) begin
            errors++;
            $display("FAIL rd_hdr: got hdr %b oe %h expected 01100000100010 fffc0000",
                     bits[31:18], oeb);
        end
        checks++;
        if (a_dout !== 16'h1234 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL rd_data: got %h err %b expected 1234 0", a_dout, a_err);
        end
        checks++;
        if (dv_cnt != 1 || dv_end !== 1'b1 || cyc != 512) begin
            errors++;
            $display("FAIL rd_dv: got pulses %0d at_ready %b cyc %0d expected 1 1 512",
                     dv_cnt, dv_end, cyc);
        end
        @(posedge clk); #1;
        checks++;
        if (a_dv !== 1'b0 || a_oe !== 1'b0 || a_mdc !== 1'b0) begin
            errors++;
            $display("FAIL rd_after: got dv %b oe %b mdc %b expected 0 0 0", a_dv, a_oe, a_mdc);
        end
    endtask

    task automatic test_no_phy;
        run_frame(1'b0, 32, 1'b0, 2'b10, 5'h07, 5'h03, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0,
                  bits, oeb, cyc, rises, pre_bad, dv_cnt, dv_end, acc);
        checks++;
        if (a_dout !== 16'hFFFF || a_err !== 1'b1 || dv_cnt != 1) begin
            errors++;
            $display("FAIL nophy: got %h err %b pulses %0d expected ffff 1 1",
                     a_dout, a_err, dv_cnt);
        end
    endtask

    task automatic test_c45;
        run_frame(1'b0, 32, 1'b1, 2'b00, 5'h03, 5'h01, 16'h0010, 16'h0, 1'b0, 1'b0, 1'b0,
                  bits, oeb, cyc, rises, pre_bad, dv_cnt, dv_end, acc);
        checks++;
        if (bits !== {2'b00, 2'b00, 5'h03, 5'h01, 2'b10, 16'h0010} || oeb !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL c45_addr: got %h oe %h expected %h ffffffff", bits, oeb,
                     {2'b00, 2'b00, 5'h03, 5'h01, 2'b10, 16'h0010});
        end
        checks++;
        if (a_err !== 1'b1 || dv_cnt != 0) begin
            errors++;
            $display("FAIL c45_addr_err: got err %b pulses %0d expected 1 0", a_err, dv_cnt);
        end
        run_frame(1'b0, 32, 1'b1, 2'b11, 5'h03, 5'h01, 16'h0, 16'hBEEF, 1'b0, 1'b0, 1'b0,
                  bits, oeb, cyc, rises, pre_bad, dv_cnt, dv_end, acc);
        checks++;
        if (!acc || bits[31:18] !== {2'b00, 2'b11, 5'h03, 5'h01}) begin
            errors++;
            $display("FAIL c45_rd_hdr: got acc %b hdr %b expected 1 00110001100001",
                     acc, bits[31:18]);
        end
        checks++;
        if (a_dout !== 16'hBEEF || a_err !== 1'b0 || dv_cnt != 1) begin
            errors++;
            $display("FAIL c45_rd_data: got %h err %b pulses %0d expected beef 0 1",
                     a_dout, a_err, dv_cnt);
        end
    endtask

    task automatic test_back_to_back;
        run_frame(1'b1, 0, 1'b0, 2'b01, 5'h0A, 5'h15, 16'h5A3C, 16'h0, 1'b0, 1'b0, 1'b1,
                  bits, oeb, cyc, rises, pre_bad, dv_cnt, dv_end, acc);
        checks++;
        if (bits[31:30] !== 2'b01) begin
            errors++;
            $display("FAIL nopre_st: got %b expected 01", bits[31:30]);
        end
        checks++;
        if (bits !== {2'b01, 2'b01, 5'h0A, 5'h15, 2'b10, 16'h5A3C} || cyc != 128 || rises != 32) begin
            errors++;
            $display("FAIL nopre_frame: got %h cyc %0d rises %0d expected %h 128 32", bits, cyc,
                     rises, {2'b01, 2'b01, 5'h0A, 5'h15, 2'b10, 16'h5A3C});
        end
        run_frame(1'b1, 0, 1'b0, 2'b00, 5'h11, 5'h06, 16'h0F0F, 16'h0, 1'b0, 1'b0, 1'b0,
                  bits, oeb, cyc, rises, pre_bad, dv_cnt, dv_end, acc);
        checks++;
        if (!acc || cyc != 128) begin
            errors++;
            $display("FAIL b2b_accept: got acc %b cyc %0d expected 1 128", acc, cyc);
        end
        checks++;
        if (bits !== {2'b01, 2'b00, 5'h11, 5'h06, 2'b10, 16'h0F0F} || oeb !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL b2b_frame: got %h oe %h expected %h ffffffff", bits, oeb,
                     {2'b01, 2'b00, 5'h11, 5'h06, 2'b10, 16'h0F0F});
        end
    endtask

    task automatic test_reset_mid;
        logic prev;
        int r, n, dvs;
        clause45 = 1'b0; op = 2'b10; phy_addr = 5'h02; reg_addr = 5'h04; data_in = 16'h0;
        mdio_i = 1'b0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        prev = 1'b0; r = 0; n = 0; dvs = 0;
        while (r < 52 && n < 4000) begin
            @(posedge clk); #1;
            n++;
            if (a_dv) dvs++;
            if (!prev && a_mdc) r++;
            prev = a_mdc;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (r != 52 || {a_rdy, a_mdc, a_oe, a_dv} !== 4'b1000) begin
            errors++;
            $display("FAIL midreset: got rises %0d rdy/mdc/oe/dv=%b expected 52 1000",
                     r, {a_rdy, a_mdc, a_oe, a_dv});
        end
        repeat (300) begin
            @(posedge clk); #1;
            if (a_dv) dvs++;
        end
        checks++;
        if (dvs != 0 || a_rdy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_dv: got pulses %0d rdy %b expected 0 1", dvs, a_rdy);
        end
        mdio_i = 1'b1;
        run_frame(1'b0, 32, 1'b0, 2'b01, 5'h1C, 5'h09, 16'hC001, 16'h0, 1'b0, 1'b0, 1'b0,
                  bits, oeb, cyc, rises, pre_bad, dv_cnt, dv_end, acc);
        checks++;
        if (bits !== {2'b01, 2'b01, 5'h1C, 5'h09, 2'b10, 16'hC001} || cyc != 512) begin
            errors++;
            $display("FAIL post_reset_wr: got %h cyc %0d expected %h 512", bits, cyc,
                     {2'b01, 2'b01, 5'h1C, 5'h09, 2'b10, 16'hC001});
        end
    endtask

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; clause45 = 1'b0; op = 2'b00;
        phy_addr = '0; reg_addr = '0; data_in = '0; mdio_i = 1'b1;
        test_reset();
        test_c22_write();
        test_c22_read();
        test_no_phy();
        test_c45();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
